// File: rtl/dp_arbiter_if.sv
// dp_arbiter_if: requester, datapath and response signals of the arbiter.
// master = surrounding system, slave = dp_arbiter.
interface dp_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         dp_data_in;
    logic [DATA_W-1:0]         dp_data_out;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_ready;
    logic                      busy;

    modport master (
        output req_valid,
        output req_data,
        output dp_data_out,
        output rsp_ready,
        input  req_ready,
        input  dp_data_in,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_data,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  dp_data_out,
        input  rsp_ready,
        output req_ready,
        output dp_data_in,
        output rsp_valid,
        output rsp_id,
        output rsp_data,
        output busy
    );
endinterface

// File: rtl/dp_arbiter.sv
// dp_arbiter: round-robin arbiter sharing one fixed-latency datapath
// between NUM_REQ requesters, one transaction in flight at a time.
module dp_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    dp_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IW    = ID_W + 1;
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    localparam logic [ID_W:0]    NREQ   = IW'(NUM_REQ);
    localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dp_in_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic [DATA_W-1:0] req_word [NUM_REQ];

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gidx;
    logic               found;
    logic [ID_W:0]      cand;
    logic [ID_W:0]      nxt;
    logic [ID_W-1:0]    ptr_nx;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_word[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    // Round-robin search: first valid requester from ptr upward, wrapping.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + IW'(k);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                gidx  = cand[ID_W-1:0];
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    // Pointer moves to the requester just after the winner.
    always_comb begin
        nxt    = {1'b0, gidx} + IW'(1);
        ptr_nx = (nxt == NREQ) ? '0 : nxt[ID_W-1:0];
    end

    // Control FSM with the registered operand and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            dp_in_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        dp_in_q  <= req_word[gidx];
                        rsp_id_q <= gidx;
                        ptr      <= ptr_nx;
                        cnt      <= LAT_LD;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_data_q  <= bus.dp_data_out;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Grants only from IDLE, and never while reset is held.
    assign bus.req_ready  = (state == IDLE && reset_n) ? grant : '0;
    assign bus.busy       = (state != IDLE);
    assign bus.dp_data_in = dp_in_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
endmodule
